seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector, generation two of the team's fixed-pattern Mealy detectors.
- Pattern, pattern length (1..MAX_LEN) and overlap mode are runtime-configurable.
- Emits a registered one-cycle match flag and keeps a saturating match count.
- Sits on a serial data path behind a deserialiser-free bit stream with per-bit valid qualifier.

---
 rtl/seq_detector_param.sv | 183 ++++++++++++++++++
 tb/tb_seq_detector_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Purpose:
//   Serial bit-pattern detector with a runtime-configurable pattern, pattern
//   length (1..MAX_LEN) and overlap mode. Bits are shifted into a history
//   register when qualified by din_valid. A registered one-cycle flag marks
//   each match, and an optional saturating counter tallies the matches.
//
// Configuration macro:
//   SEQDET_MATCH_CNT_EN - when defined, the match counter and cnt_clr are
//                         built. When undefined, match_cnt is tied to 0 and
//                         cnt_clr is ignored. flag behaves the same in both.
//
// Ports:
//   clk         - clock; all state updates on the rising edge
//   rst         - asynchronous active-high reset
//   en          - detector enable; 0 forces IDLE and clears history/fill
//   din         - serial data bit
//   din_valid   - din is sampled only when 1
//   cfg_load    - load cfg_pat/cfg_len/cfg_overlap into the shadow config
//                 and restart detection
//   cfg_pat     - pattern; bit [len-1] is the first bit received, bit 0 last
//   cfg_len     - pattern length
//   cfg_overlap - 1 = overlapping matches allowed
//   cnt_clr     - synchronous clear of match_cnt (wins over a match)
//   flag        - registered match pulse, one cycle after the matching bit
//   match_cnt   - saturating match count
//   cfg_err     - shadow length is 0 or greater than MAX_LEN
// ---------------------------------------------------------------------------
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               flag,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HUNT = 2'd2;

  localparam logic [LEN_W:0] MAX_LEN_EXT = (LEN_W + 1)'(MAX_LEN);

  logic [1:0]         state_q,   state_d;
  logic [MAX_LEN-1:0] hist_q,    hist_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  logic               flag_q,    flag_d;
  logic [MAX_LEN-1:0] pat_q,     pat_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic               overlap_q, overlap_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] new_hist;
  logic [LEN_W:0]     fill_plus;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] pat_mask;
  logic               load_err;
  logic               match;

  // Candidate values for an accepted bit. Shifting all-ones left by len
  // yields zero when len equals MAX_LEN, so the mask becomes all ones.
  always_comb begin
    new_hist  = {hist_q[MAX_LEN-2:0], din};
    fill_plus = {1'b0, fill_q} + (LEN_W + 1)'(1);
    fill_inc  = (fill_plus > MAX_LEN_EXT) ? MAX_LEN_EXT[LEN_W-1:0]
                                          : fill_plus[LEN_W-1:0];
    pat_mask  = ~({MAX_LEN{1'b1}} << len_q);
    load_err  = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
  end

  // Next-state logic. Priority: cfg_load, then en=0, then IDLE wake-up,
  // then bit acceptance. A match is only possible on an accepted bit.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    flag_d    = 1'b0;
    pat_d     = pat_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    cfg_err_d = cfg_err_q;
    match     = 1'b0;

    if (cfg_load) begin
      pat_d     = cfg_pat;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      cfg_err_d = load_err;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = (en && !load_err) ? ST_FILL : ST_IDLE;
    end else if (!en) begin
      state_d = ST_IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (state_q == ST_IDLE) begin
      if (!cfg_err_q) begin
        state_d = ST_FILL;
      end
    end else if (din_valid) begin
      hist_d = new_hist;
      match  = (fill_plus >= {1'b0, len_q}) &&
               (((new_hist ^ pat_q) & pat_mask) == '0);
      flag_d = match;
      if (match && !overlap_q) begin
        fill_d = '0;
      end else begin
        fill_d = fill_inc;
      end
      state_d = (fill_d >= len_q) ? ST_HUNT : ST_FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      flag_q    <= 1'b0;
      pat_q     <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      cfg_err_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      flag_q    <= flag_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign flag    = flag_q;
  assign cfg_err = cfg_err_q;

`ifdef SEQDET_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear takes priority over a coincident match; count saturates at max.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Self-checking bench for seq_detector_param (MAX_LEN=8, CNT_W=2 so the
// counter saturates quickly). A behavioural model predicts flag, match_cnt
// and cfg_err for every driven cycle; predictions are queued when stimulus
// is applied and popped once the DUT has registered the edge.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               din;
  logic               din_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               flag;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  seq_detector_param #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .cfg_load   (cfg_load),
    .cfg_pat    (cfg_pat),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .flag       (flag),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp_flag;
    int exp_cnt;
    int exp_err;
  } expect_t;

  expect_t sb_q[$];

  int checks = 0;
  int fails  = 0;
  int flags_seen;
  int cyc = 0;

  // Model state
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 m_err;
  bit                 m_active;
  bit                 m_hist[$];
  int                 m_fill;
  int                 m_cnt;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_pat    = '0;
    m_len    = 0;
    m_ovl    = 1'b0;
    m_err    = 1'b1;
    m_active = 1'b0;
    m_hist.delete();
    m_fill   = 0;
    m_cnt    = 0;
  endtask

  // Predicts the registered outputs produced by the coming edge.
  task automatic modelStep(input bit en_i, input bit din_i, input bit valid_i,
                           input bit load_i, input bit clr_i, output expect_t e);
    bit matched;
    matched = 1'b0;
    if (load_i) begin
      m_pat    = cfg_pat;
      m_len    = int'(cfg_len);
      m_ovl    = cfg_overlap;
      m_err    = (m_len == 0) || (m_len > MAX_LEN);
      m_hist.delete();
      m_fill   = 0;
      m_active = en_i && !m_err;
    end else if (!en_i) begin
      m_active = 1'b0;
      m_hist.delete();
      m_fill   = 0;
    end else if (!m_active) begin
      m_active = !m_err;
    end else if (valid_i) begin
      m_hist.push_back(din_i);
      if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
      if (m_fill < MAX_LEN) m_fill++;
      if (m_fill >= m_len) begin
        matched = 1'b1;
        // Newest bit pairs with pattern bit 0, oldest with bit len-1.
        for (int k = 0; k < m_len; k++) begin
          if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) matched = 1'b0;
        end
      end
      if (matched && !m_ovl) m_fill = 0;
    end
`ifdef SEQDET_MATCH_CNT_EN
    if (clr_i) m_cnt = 0;
    else if (matched && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`else
    m_cnt = 0;
`endif
    e.exp_flag = matched ? 1 : 0;
    e.exp_cnt  = m_cnt;
    e.exp_err  = m_err ? 1 : 0;
  endtask

  // Drives one cycle of inputs, queues the prediction, then checks it.
  task automatic applyStimulus(input bit en_i, input bit din_i, input bit valid_i,
                               input bit load_i, input bit clr_i);
    expect_t e;
    expect_t got;
    en        = en_i;
    din       = din_i;
    din_valid = valid_i;
    cfg_load  = load_i;
    cnt_clr   = clr_i;
    modelStep(en_i, din_i, valid_i, load_i, clr_i, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = sb_q.pop_front();
    checkOutput($sformatf("flag@%0d", cyc), int'(flag), got.exp_flag);
    checkOutput($sformatf("cnt@%0d", cyc), int'(match_cnt), got.exp_cnt);
    checkOutput($sformatf("err@%0d", cyc), int'(cfg_err), got.exp_err);
    if (flag) flags_seen++;
  endtask

  task automatic loadCfg(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
    cfg_pat     = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    flags_seen = 0;
  endtask

  task automatic streamBits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #3;
    checkOutput("rst_flag", int'(flag), 0);
    checkOutput("rst_cnt", int'(match_cnt), 0);
    checkOutput("rst_err", int'(cfg_err), 1);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    en = 0; din = 0; din_valid = 0; cfg_load = 0; cnt_clr = 0;
    cfg_pat = '0; cfg_len = '0; cfg_overlap = 0; rst = 0; flags_seen = 0;
    modelReset();
    @(negedge clk);
    applyReset();

    // Inert before first load
    streamBits(32'b1111, 4);
    checkOutput("inert_flags", flags_seen, 0);

    // 01010101 overlap: flags after bit 8 and bit 10
    loadCfg(8'b01010101, 8, 1'b1);
    streamBits(32'b0101010101, 10);
    checkOutput("alt_ovl_flags", flags_seen, 2);
`ifdef SEQDET_MATCH_CNT_EN
    checkOutput("alt_ovl_cnt", int'(match_cnt), 2);
`else
    checkOutput("alt_ovl_cnt", int'(match_cnt), 0);
`endif

    // Same stream without overlap: single flag
    loadCfg(8'b01010101, 8, 1'b0);
    streamBits(32'b0101010101, 10);
    checkOutput("alt_novl_flags", flags_seen, 1);

    // 111 overlap: three consecutive flags; non-overlap: one
    loadCfg(8'b111, 3, 1'b1);
    streamBits(32'b11111, 5);
    checkOutput("ones_ovl_flags", flags_seen, 3);
    loadCfg(8'b111, 3, 1'b0);
    streamBits(32'b11111, 5);
    checkOutput("ones_novl_flags", flags_seen, 1);

    // 1011 with a din_valid gap
    loadCfg(8'b1011, 4, 1'b1);
    streamBits(32'b10, 2);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    streamBits(32'b11, 2);
    checkOutput("gap_flags", flags_seen, 1);

    // cfg_load coinciding with the 4th bit discards it and restarts
    loadCfg(8'b1011, 4, 1'b1);
    streamBits(32'b101, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    streamBits(32'b011, 3);
    checkOutput("load_mid_flags", flags_seen, 0);

    // Illegal lengths
    loadCfg(8'hFF, 0, 1'b1);
    checkOutput("len0_err", int'(cfg_err), 1);
    streamBits(32'hFF, 8);
    loadCfg(8'hFF, MAX_LEN + 1, 1'b1);
    checkOutput("len9_err", int'(cfg_err), 1);
    streamBits(32'hFF, 8);
    checkOutput("len9_flags", flags_seen, 0);

    // en dropped mid-pattern discards the partial match
    loadCfg(8'b1011, 4, 1'b1);
    checkOutput("len4_err", int'(cfg_err), 0);
    streamBits(32'b10, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    streamBits(32'b11, 2);
    checkOutput("en_drop_flags", flags_seen, 0);
    streamBits(32'b011, 3);
    checkOutput("en_resume_flags", flags_seen, 1);

    // Saturation with a length-1 pattern, then clear against a match
    loadCfg(8'b1, 1, 1'b1);
    streamBits(32'b11111, 5);
`ifdef SEQDET_MATCH_CNT_EN
    checkOutput("sat_cnt", int'(match_cnt), 3);
`else
    checkOutput("sat_cnt", int'(match_cnt), 0);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_cnt", int'(match_cnt), 0);
    checkOutput("clr_flag", int'(flag), 1);

    // Randomised stream against the model
    loadCfg(8'b110, 3, 1'b0);
    for (int i = 0; i < 150; i++) begin
      applyStimulus(($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0, ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 29) == 0));
    end
    loadCfg(8'b10100111, 8, 1'b1);
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0,
                    1'b0, 1'b0);
    end

    // Reset mid-stream: nothing survives, detector is inert again
    loadCfg(8'b1011, 4, 1'b1);
    streamBits(32'b101, 3);
    @(negedge clk);
    applyReset();
    streamBits(32'b1011, 4);
    checkOutput("post_rst_flags", flags_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
